tour_cmd: RTL and testbench



---
 rtl/tour_cmd.sv | 168 ++++++++++++++++
 tb/tb_tour_cmd.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - replays a solved knight's tour as vertical/horizontal move commands
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        HOLD_V = 3'd2,
        HORZ   = 3'd3,
        HOLD_H = 3'd4
    } state_t;

    localparam logic [4:0]  LAST_INDX   = 5'd23;
    localparam logic [3:0]  OP_VERT     = 4'h2;
    localparam logic [3:0]  OP_HORZ     = 4'h3;
    localparam logic [7:0]  HDG_NORTH   = 8'h00;
    localparam logic [7:0]  HDG_SOUTH   = 8'h7F;
    localparam logic [7:0]  HDG_EAST    = 8'hBF;
    localparam logic [7:0]  HDG_WEST    = 8'h3F;
    localparam logic [7:0]  HDG_NONE    = 8'h00;
    localparam logic [7:0]  RESP_IDLE   = 8'hA5;
    localparam logic [7:0]  RESP_TOUR   = 8'h5A;

    state_t state;

    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic [2:0]        dx_mag;
    logic [2:0]        dy_mag;
    logic [7:0]        vert_hdg;
    logic [7:0]        horz_hdg;
    logic [15:0]       vert_cmd;
    logic [15:0]       horz_cmd;

    // Knight move decode: only a single set bit names a move, anything else is a null move
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (move)
            8'h01: begin dx = -3'sd1; dy =  3'sd2; end
            8'h02: begin dx =  3'sd1; dy =  3'sd2; end
            8'h04: begin dx = -3'sd2; dy =  3'sd1; end
            8'h08: begin dx = -3'sd2; dy = -3'sd1; end
            8'h10: begin dx = -3'sd1; dy = -3'sd2; end
            8'h20: begin dx =  3'sd1; dy = -3'sd2; end
            8'h40: begin dx =  3'sd2; dy = -3'sd1; end
            8'h80: begin dx =  3'sd2; dy =  3'sd1; end
            default: begin dx = 3'sd0; dy = 3'sd0; end
        endcase
    end

    // Build the two legs of the move: north/south first, then east/west with fanfare
    always_comb begin
        dx_mag = dx[2] ? 3'(-dx) : 3'(dx);
        dy_mag = dy[2] ? 3'(-dy) : 3'(dy);

        if (dy > 3'sd0)
            vert_hdg = HDG_NORTH;
        else if (dy < 3'sd0)
            vert_hdg = HDG_SOUTH;
        else
            vert_hdg = HDG_NONE;

        if (dx > 3'sd0)
            horz_hdg = HDG_EAST;
        else if (dx < 3'sd0)
            horz_hdg = HDG_WEST;
        else
            horz_hdg = HDG_NONE;

        vert_cmd = {OP_VERT, vert_hdg, 1'b0, dy_mag};
        horz_cmd = {OP_HORZ, horz_hdg, 1'b0, dx_mag};
    end

    // Output mux: UART passthrough when idle, otherwise the current leg with no added latency
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_IDLE;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_IDLE;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_TOUR;
            end
            HOLD_V: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                resp    = RESP_TOUR;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_TOUR;
            end
            HOLD_H: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                resp    = RESP_TOUR;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_IDLE;
            end
        endcase
    end

    // Tour sequencer: each index issues a vertical then a horizontal leg, acked then completed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx <= 5'd0;
                        state   <= VERT;
                    end
                end
                VERT: begin
                    if (clr_cmd_rdy)
                        state <= HOLD_V;
                end
                HOLD_V: begin
                    if (send_resp)
                        state <= HORZ;
                end
                HORZ: begin
                    if (clr_cmd_rdy)
                        state <= HOLD_H;
                end
                HOLD_H: begin
                    if (send_resp) begin
                        if (mv_indx == LAST_INDX) begin
                            state <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= VERT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - randomized and directed checks of tour_cmd against a command-count model
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move = 8'h00;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    tour_cmd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Model: a tour is 48 commands; command n belongs to index n/2 and is horizontal when n is odd
    bit         m_tour  = 0;
    bit         m_acked = 0;
    int         m_num   = 0;
    int         m_idx   = 0;
    bit         uart_quiet = 0;
    logic [7:0] tour_moves [24];

    int dx_t [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int dy_t [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit horiz);
        int dx = 0;
        int dy = 0;
        int d;
        logic [7:0] hd;
        logic [3:0] op;
        if ($countones(mv) == 1) begin
            for (int i = 0; i < 8; i++) begin
                if (mv[i]) begin
                    dx = dx_t[i];
                    dy = dy_t[i];
                end
            end
        end
        d  = horiz ? dx : dy;
        op = horiz ? 4'h3 : 4'h2;
        if (horiz)
            hd = (d > 0) ? 8'hBF : (d < 0) ? 8'h3F : 8'h00;
        else
            hd = (d > 0) ? 8'h00 : (d < 0) ? 8'h7F : 8'h00;
        return {op, hd, 4'(d < 0 ? -d : d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic [7:0]  e_resp;
        if (m_tour) begin
            e_cmd  = exp_cmd(move, (m_num % 2) == 1);
            e_rdy  = !m_acked;
            e_resp = 8'h5A;
        end else begin
            e_cmd  = cmd_UART;
            e_rdy  = cmd_rdy_UART;
            e_resp = 8'hA5;
        end
        chk({tag, "_cmd"},     32'(cmd),     32'(e_cmd));
        chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'(e_rdy));
        chk({tag, "_resp"},    32'(resp),    32'(e_resp));
        chk({tag, "_mv_indx"}, 32'(mv_indx), 32'(m_idx));
    endtask

    task automatic drive_free();
        move         = m_tour ? tour_moves[m_idx] : 8'($urandom);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = uart_quiet ? 1'b0 : 1'($urandom);
    endtask

    task automatic cyc(input logic st, input logic clr, input logic sr);
        start_tour  = st;
        clr_cmd_rdy = clr;
        send_resp   = sr;
        if (m_tour && cmd_rdy && clr) pulses++;
        @(posedge clk);
        if (!rst_n) begin
            m_tour = 0;
            m_idx  = 0;
        end else if (!m_tour) begin
            if (st) begin
                m_tour  = 1;
                m_num   = 0;
                m_acked = 0;
                m_idx   = 0;
            end
        end else if (!m_acked) begin
            if (clr) m_acked = 1;
        end else if (sr) begin
            m_acked = 0;
            if (m_num == 47) begin
                m_tour = 0;
            end else begin
                m_num++;
                m_idx = m_num / 2;
            end
        end
        #1;
        start_tour  = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        drive_free();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic run_prompt(input int stop_num);
        for (int k = 0; k < 400; k++) begin
            if (!m_tour || (m_num == stop_num && m_acked)) break;
            if (m_acked) cyc(1'b0, 1'b0, 1'b1);
            else         cyc(1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 24; i++)
            tour_moves[i] = 8'(1 << $urandom_range(0, 7));

        // Reset state
        drive_free();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset_resp", 32'(resp), 32'h0000_00A5);
        rst_n = 1'b1;

        // UART passthrough
        cmd_UART     = 16'h2F02;
        cmd_rdy_UART = 1'b1;
        #1;
        chk("pass_cmd",  32'(cmd),     32'h0000_2F02);
        chk("pass_rdy",  32'(cmd_rdy), 32'd1);
        chk("pass_resp", 32'(resp),    32'h0000_00A5);
        @(negedge clk);

        // Directed tour start with the decode sweep on the first four indices
        tour_moves[0] = 8'h02;
        tour_moves[1] = 8'h08;
        tour_moves[2] = 8'h40;
        tour_moves[3] = 8'h00;
        pulses = 0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("m02_vert", 32'(cmd), 32'h0000_2002);
        cyc(1'b0, 1'b0, 1'b1);
        chk("vert_ignore_resp", 32'(cmd_rdy), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("hold_v_rdy", 32'(cmd_rdy), 32'd0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("m02_horz", 32'(cmd), 32'h0000_3BF1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("horz_clr_and_resp_rdy",  32'(cmd_rdy), 32'd0);
        chk("horz_clr_and_resp_indx", 32'(mv_indx), 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m08_vert", 32'(cmd), 32'h0000_27F1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m08_horz", 32'(cmd), 32'h0000_33F2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m40_vert", 32'(cmd), 32'h0000_27F1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m40_horz", 32'(cmd), 32'h0000_3BF2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m00_vert", 32'(cmd), 32'h0000_2000);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("m00_horz", 32'(cmd), 32'h0000_3000);
        run_prompt(-1);
        chk("tour1_pulses", 32'(pulses),  32'd48);
        chk("tour1_indx",   32'(mv_indx), 32'd23);
        chk("tour1_resp",   32'(resp),    32'h0000_00A5);

        // Randomized tour: random moves, random acks, stray start_tour pulses
        for (int i = 0; i < 24; i++)
            tour_moves[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            if (!m_tour) break;
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end
        chk("tour2_done_resp", 32'(resp),    32'h0000_00A5);
        chk("tour2_done_indx", 32'(mv_indx), 32'd23);

        // Mid-tour reset while holding the horizontal leg of index 7
        for (int i = 0; i < 24; i++)
            tour_moves[i] = 8'(1 << $urandom_range(0, 7));
        cyc(1'b1, 1'b0, 1'b0);
        run_prompt(15);
        chk("pre_reset_indx", 32'(mv_indx), 32'd7);
        chk("pre_reset_resp", 32'(resp),    32'h0000_005A);
        uart_quiet   = 1;
        cmd_rdy_UART = 1'b0;
        #2;
        rst_n   = 1'b0;
        m_tour  = 0;
        m_acked = 0;
        m_idx   = 0;
        #1;
        check_all("async_reset");
        cyc(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++)
            cyc(1'b0, 1'($urandom), 1'($urandom));
        chk("post_reset_rdy",  32'(cmd_rdy), 32'd0);
        chk("post_reset_indx", 32'(mv_indx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
